gcd_client: RTL and testbench

//  Initiator side of the GCD unit's operand/result handshake. Buffers operand pairs

---
 rtl/gcd_client_if.sv | 33 +++
 rtl/gcd_client.sv | 138 +++++++++++++
 tb/tb_gcd_client.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_client_if.sv
// gcd_client_if: upstream request/response and GCD-unit operand/result handshakes.
// master is the client side; slave is the upstream source plus the GCD unit.
interface gcd_client_if #(
  parameter int unsigned W = 16
);
  logic         req_val;
  logic         req_rdy;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         gcd_opnd_val;
  logic         gcd_opnd_rdy;
  logic [W-1:0] gcd_opnd_a;
  logic [W-1:0] gcd_opnd_b;
  logic         gcd_res_val;
  logic         gcd_res_rdy;
  logic [W-1:0] gcd_res_data;
  logic         rsp_val;
  logic         rsp_rdy;
  logic [W-1:0] rsp_data;
  logic         rsp_err;

  modport master (
    input  req_val, req_a, req_b, gcd_opnd_rdy, gcd_res_val, gcd_res_data, rsp_rdy,
    output req_rdy, gcd_opnd_val, gcd_opnd_a, gcd_opnd_b, gcd_res_rdy, rsp_val, rsp_data,
           rsp_err
  );

  modport slave (
    output req_val, req_a, req_b, gcd_opnd_rdy, gcd_res_val, gcd_res_data, rsp_rdy,
    input  req_rdy, gcd_opnd_val, gcd_opnd_a, gcd_opnd_b, gcd_res_rdy, rsp_val, rsp_data,
           rsp_err
  );
endinterface

// File: rtl/gcd_client.sv
// gcd_client: queues operand pairs, issues them one at a time to a GCD unit and returns
// results upstream in order. Define GCD_CLIENT_TIMEOUT_EN to abort stalled WAIT states.
module gcd_client #(
  parameter int unsigned W           = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         reset,
  gcd_client_if.master bus,
  output logic         busy,
  output logic [15:0]  txn_count
);
  localparam int unsigned AddrW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("gcd_client: DEPTH must be a power of two >= 2 and TIMEOUT_CYC nonzero");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
  state_e state_q, state_d;

  logic [2*W-1:0] mem_q [DEPTH];
  logic [AddrW:0] wr_ptr_q, rd_ptr_q;
  logic           empty, full, push, pop;
  logic [W-1:0]   opnd_a_q, opnd_b_q, rsp_data_q;
  logic [15:0]    txn_count_q;
  logic           load_opnd, capture_res, abort, accept_rsp, expired;

  // Extra pointer bit separates full from empty when the low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign push  = bus.req_val && !full;

`ifdef GCD_CLIENT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;
  logic [CntW-1:0] wait_cnt_q;
  logic            rsp_err_q;

  // Counter reads 0 on the first WAIT cycle, so expiry lands on WAIT cycle TIMEOUT_CYC.
  assign expired = (wait_cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state_q != StWait) wait_cnt_q <= '0;
      else                   wait_cnt_q <= wait_cnt_q + 1'b1;
      if (capture_res)       rsp_err_q  <= 1'b0;
      else if (abort)        rsp_err_q  <= 1'b1;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign expired     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    load_opnd        = 1'b0;
    pop              = 1'b0;
    capture_res      = 1'b0;
    abort            = 1'b0;
    accept_rsp       = 1'b0;
    bus.gcd_opnd_val = 1'b0;
    bus.gcd_res_rdy  = 1'b0;
    bus.rsp_val      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          load_opnd = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        bus.gcd_opnd_val = 1'b1;
        if (bus.gcd_opnd_rdy) begin
          pop     = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        bus.gcd_res_rdy = 1'b1;
        // A result arriving on the expiry cycle takes priority over the abort.
        if (bus.gcd_res_val) begin
          capture_res = 1'b1;
          state_d     = StResp;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        bus.rsp_val = 1'b1;
        if (bus.rsp_rdy) begin
          accept_rsp = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      opnd_a_q    <= '0;
      opnd_b_q    <= '0;
      rsp_data_q  <= '0;
      txn_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (load_opnd) {opnd_a_q, opnd_b_q} <= mem_q[rd_ptr_q[AddrW-1:0]];
      if (capture_res)  rsp_data_q <= bus.gcd_res_data;
      else if (abort)   rsp_data_q <= '0;
      if (accept_rsp)   txn_count_q <= txn_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= {bus.req_a, bus.req_b};
  end

  assign bus.req_rdy    = !full;
  assign bus.gcd_opnd_a = opnd_a_q;
  assign bus.gcd_opnd_b = opnd_b_q;
  assign bus.rsp_data   = rsp_data_q;
  assign busy           = (state_q != StIdle) || !empty;
  assign txn_count      = txn_count_q;
endmodule

// File: tb/tb_gcd_client.sv
// tb_gcd_client: directed and randomized checks of gcd_client against a GCD-unit model
// and an in-order result scoreboard.
module tb_gcd_client;
  localparam int unsigned W       = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [15:0] txn_count;

  gcd_client_if #(.W(W)) bus ();

  gcd_client #(.W(W), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Knobs for the GCD-unit model, written only by the main sequence.
  int gcd_delay   = 0;
  bit gcd_respond = 1'b1;
  bit spurious    = 1'b0;

  // Written only by the model/monitor process.
  logic        g_busy, g_have, fire_o, fire_r;
  int          g_cnt;
  logic [15:0] g_res, cap_a, cap_b, last_a, last_b;
  int          issued, got_n;
  logic [15:0] got_data [64];
  logic        got_err  [64];

  // Phase negedge+1: apply last edge's transfers; negedge+3: decide the next edge's transfers.
  initial begin : gcd_unit_model
    g_busy = 1'b0; g_have = 1'b0; fire_o = 1'b0; fire_r = 1'b0; g_cnt = 0;
    g_res = '0; cap_a = '0; cap_b = '0; last_a = '0; last_b = '0; issued = 0; got_n = 0;
    bus.gcd_opnd_rdy = 1'b0; bus.gcd_res_val = 1'b0; bus.gcd_res_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        g_busy = 1'b0;
        g_have = 1'b0;
      end else begin
        if (fire_r) g_have = 1'b0;
        if (fire_o) begin
          g_busy = 1'b1;
          g_cnt  = gcd_delay;
          g_res  = gcd_ref(cap_a, cap_b);
        end else if (g_busy) begin
          if (g_cnt > 0) g_cnt--;
          else if (gcd_respond) begin
            g_busy = 1'b0;
            g_have = 1'b1;
          end
        end
      end
      bus.gcd_opnd_rdy = !g_busy && !g_have;
      bus.gcd_res_val  = g_have || (spurious && !g_busy);
      bus.gcd_res_data = g_have ? g_res : 16'hbeef;
      #2;
      fire_o = !reset && bus.gcd_opnd_val && bus.gcd_opnd_rdy;
      fire_r = !reset && g_have && bus.gcd_res_rdy;
      if (fire_o) begin
        cap_a  = bus.gcd_opnd_a;
        cap_b  = bus.gcd_opnd_b;
        last_a = cap_a;
        last_b = cap_b;
        issued++;
      end
      if (!reset && bus.rsp_val && bus.rsp_rdy) begin
        got_data[got_n % 64] = bus.rsp_data;
        got_err[got_n % 64]  = bus.rsp_err;
        got_n++;
      end
    end
  end

  int          vectors = 0;
  int          miscompares = 0;
  int          pushed = 0;
  int          got_rd = 0;
  int          txn_base = 0;
  bit          rand_rdy = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
    if (rand_rdy) bus.rsp_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    bit done = 1'b0;
    bus.req_a   = a;
    bus.req_b   = b;
    bus.req_val = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      check("req_rdy_vs_occupancy", 32'(bus.req_rdy), 32'((pushed - issued) < int'(DEPTH)));
      if (bus.req_rdy) begin
        pushed++;
        exp_q.push_back(gcd_ref(a, b));
        done = 1'b1;
      end
      step();
    end
    bus.req_val = 1'b0;
    check("push_accepted", 32'(done), 32'(1));
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget && (got_n - got_rd) < n; i++) step();
    check("rsp_arrived", 32'((got_n - got_rd) >= n), 32'(1));
  endtask

  task automatic pop_rsp();
    check("rsp_data", 32'(got_data[got_rd % 64]), 32'(exp_q.pop_front()));
    check("rsp_err", 32'(got_err[got_rd % 64]), 32'(0));
    got_rd++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.req_val = 1'b0;
    step();
    step();
    reset    = 1'b0;
    pushed   = issued;
    got_rd   = got_n;
    txn_base = got_n;
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_rdy"},  32'(bus.req_rdy),      32'(1));
    check({tag, "_opnd_val"}, 32'(bus.gcd_opnd_val), 32'(0));
    check({tag, "_res_rdy"},  32'(bus.gcd_res_rdy),  32'(0));
    check({tag, "_rsp_val"},  32'(bus.rsp_val),      32'(0));
    check({tag, "_rsp_err"},  32'(bus.rsp_err),      32'(0));
    check({tag, "_rsp_data"}, 32'(bus.rsp_data),     32'(0));
    check({tag, "_opnd_a"},   32'(bus.gcd_opnd_a),   32'(0));
    check({tag, "_opnd_b"},   32'(bus.gcd_opnd_b),   32'(0));
    check({tag, "_busy"},     32'(busy),             32'(0));
    check({tag, "_txn"},      32'(txn_count),        32'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main_seq
    logic [15:0] pa [5];
    logic [15:0] pb [5];
    int          iss0, n, cnt, k;

    reset = 1'b1;
    bus.req_val = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.rsp_rdy = 1'b0;
    do_reset();
    check_idle_outputs("por");

    // Single transaction.
    bus.rsp_rdy = 1'b1;
    gcd_delay   = 5;
    iss0        = issued;
    push(16'd27, 16'd15);
    wait_rsp(1, 100);
    check("t1_issues", 32'(issued - iss0), 32'(1));
    check("t1_opnd_a", 32'(last_a), 32'(27));
    check("t1_opnd_b", 32'(last_b), 32'(15));
    pop_rsp();
    check("t1_txn", 32'(txn_count), 32'(1));

    // Five back-to-back pushes fill the FIFO.
    pa = '{16'd12, 16'd100, 16'd17, 16'd64, 16'd81};
    pb = '{16'd18, 16'd75,  16'd5,  16'd48, 16'd27};
    gcd_delay = 8;
    for (int i = 0; i < 5; i++) push(pa[i], pb[i]);
    check("t2_req_rdy_full", 32'(bus.req_rdy), 32'(0));
    wait_rsp(5, 500);
    for (int i = 0; i < 5; i++) pop_rsp();
    check("t2_txn", 32'(txn_count), 32'(6));

    // Upstream backpressure in RESP.
    bus.rsp_rdy = 1'b0;
    gcd_delay   = 2;
    push(16'd40, 16'd24);
    for (int i = 0; i < 50 && !bus.rsp_val; i++) step();
    check("t3_rsp_val", 32'(bus.rsp_val), 32'(1));
    push(16'd9, 16'd6);
    push(16'd35, 16'd49);
    push(16'd1000, 16'd250);
    push(16'd7, 16'd3);
    check("t3_req_rdy_full", 32'(bus.req_rdy), 32'(0));
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_val", 32'(bus.rsp_val), 32'(1));
      check("t3_hold_data", 32'(bus.rsp_data), 32'(exp_q[0]));
      check("t3_no_issue", 32'(bus.gcd_opnd_val), 32'(0));
      step();
    end
    check("t3_none_returned", 32'(got_n - got_rd), 32'(0));
    bus.rsp_rdy = 1'b1;
    wait_rsp(5, 500);
    for (int i = 0; i < 5; i++) pop_rsp();
    check("t3_txn", 32'(txn_count), 32'(got_n - txn_base));

    // Reset mid-WAIT with three pairs still queued.
    gcd_respond = 1'b0;
    push(16'd30, 16'd20);
    push(16'd44, 16'd11);
    push(16'd60, 16'd36);
    push(16'd90, 16'd12);
    for (int i = 0; i < 50 && !bus.gcd_res_rdy; i++) step();
    check("t4_in_wait", 32'(bus.gcd_res_rdy), 32'(1));
    check("t4_busy", 32'(busy), 32'(1));
    do_reset();
    check_idle_outputs("t4_rst");
    gcd_respond = 1'b1;
    iss0        = issued;
    push(16'd8, 16'd12);
    wait_rsp(1, 100);
    check("t4_rsp_data", 32'(got_data[got_rd % 64]), 32'(4));
    pop_rsp();
    check("t4_issues", 32'(issued - iss0), 32'(1));
    check("t4_txn", 32'(txn_count), 32'(1));

    // Spurious result while idle.
    for (int i = 0; i < 3; i++) step();
    spurious = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t5_rsp_val", 32'(bus.rsp_val), 32'(0));
      check("t5_res_rdy", 32'(bus.gcd_res_rdy), 32'(0));
    end
    spurious = 1'b0;
    step();
    check("t5_no_rsp", 32'(got_n - got_rd), 32'(0));
    check("t5_txn", 32'(txn_count), 32'(1));

    // Randomized traffic with random GCD latency and upstream backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      gcd_delay = int'($urandom_range(0, 6));
      k = int'($urandom_range(1, 40));
      push(16'(k * int'($urandom_range(0, 100))), 16'(k * int'($urandom_range(1, 100))));
      repeat ($urandom_range(0, 2)) step();
    end
    n = exp_q.size();
    wait_rsp(n, 3000);
    for (int i = 0; i < n; i++) pop_rsp();
    rand_rdy    = 1'b0;
    bus.rsp_rdy = 1'b1;
    step();
    check("rand_txn", 32'(txn_count), 32'(got_n - txn_base));

`ifdef GCD_CLIENT_TIMEOUT_EN
    // GCD unit never answers: abort after TIMEOUT WAIT cycles.
    gcd_respond = 1'b0;
    bus.rsp_rdy = 1'b0;
    push(16'd9, 16'd6);
    for (int i = 0; i < 20 && !bus.gcd_res_rdy; i++) step();
    cnt = 0;
    while (bus.gcd_res_rdy && cnt < 100) begin
      cnt++;
      step();
    end
    check("to_wait_cycles", 32'(cnt), 32'(TIMEOUT));
    check("to_rsp_val", 32'(bus.rsp_val), 32'(1));
    check("to_rsp_err", 32'(bus.rsp_err), 32'(1));
    check("to_rsp_data", 32'(bus.rsp_data), 32'(0));
    bus.rsp_rdy = 1'b1;
    step();
    step();
    check("to_idle", 32'(busy), 32'(0));
    check("to_got_err", 32'(got_err[got_rd % 64]), 32'(1));
    check("to_txn", 32'(txn_count), 32'(got_n - txn_base));
    got_rd++;
    void'(exp_q.pop_front());
    do_reset();
    gcd_respond = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
